// File: rtl/operand_stage_pkg.sv
// Shared definitions for the operand/issue stage: word layout, opcodes and
// the write-back predicate used for hazard checking and scoreboard updates.
package operand_stage_pkg;

  localparam int WORD_W  = 16;
  localparam int NUM_REG = 64;
  localparam int REG_W   = 6;

  // Instruction word fields
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int DEST_HI = 11;
  localparam int DEST_LO = 6;
  localparam int SRC_HI  = 5;
  localparam int SRC_LO  = 0;

  // Opcodes 0..11 produce a result; 12..15 are pass-through (ALU returns in1)
  localparam logic [3:0] OPadd  = 4'h0;
  localparam logic [3:0] OPsub  = 4'h1;
  localparam logic [3:0] OPmul  = 4'h2;
  localparam logic [3:0] OPand  = 4'h3;
  localparam logic [3:0] OPor   = 4'h4;
  localparam logic [3:0] OPxor  = 4'h5;
  localparam logic [3:0] OPshl  = 4'h6;
  localparam logic [3:0] OPshr  = 4'h7;
  localparam logic [3:0] OPfadd = 4'h8;
  localparam logic [3:0] OPfmul = 4'h9;
  localparam logic [3:0] OPf2i  = 4'hA;
  localparam logic [3:0] OPi2f  = 4'hB;

  localparam logic [3:0] WRITES_DEST_MAX = OPi2f;

  function automatic logic writes_dest(input logic [3:0] opcode);
    return (opcode <= WRITES_DEST_MAX);
  endfunction

endpackage

// File: rtl/operand_stage_scoreboard.sv
// Per-register pending bits for in-flight results. Two query ports report
// pending state with a same-cycle clear already applied. Set beats clear.
module op_scoreboard
  import operand_stage_pkg::*;
#(
  parameter int NREGS   = NUM_REG,
  parameter int REGBITS = REG_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_set_en,
  input  logic [REGBITS-1:0] i_set_reg,
  input  logic               i_clr_en,
  input  logic [REGBITS-1:0] i_clr_reg,
  input  logic [REGBITS-1:0] i_qa_reg,
  input  logic [REGBITS-1:0] i_qb_reg,
  output logic               o_qa_pend,
  output logic               o_qb_pend
);

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_pending_nxt;

  // Next pending vector: clear first, then set so a collision leaves it set
  always_comb begin
    w_pending_nxt = r_pending;
    if (i_clr_en) w_pending_nxt[i_clr_reg] = 1'b0;
    if (i_set_en) w_pending_nxt[i_set_reg] = 1'b1;
  end

  // Query ports see the effect of a writeback landing this cycle
  always_comb begin
    o_qa_pend = r_pending[i_qa_reg] && !(i_clr_en && (i_clr_reg == i_qa_reg));
    o_qb_pend = r_pending[i_qb_reg] && !(i_clr_en && (i_clr_reg == i_qb_reg));
  end

  // Pending register with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!reset) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

endmodule

// File: rtl/operand_stage.sv
// Register-read / issue stage ahead of the ALU. Reads Dest and Src from the
// register file with writeback bypass, stalls on pending results, and holds
// the issued instruction in an output register behind a valid/ready handshake.
module operand_stage
  import operand_stage_pkg::*;
#(
  parameter int WIDTH   = WORD_W,
  parameter int NREGS   = NUM_REG,
  parameter int REGBITS = REG_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   ir,
  input  logic               ir_valid,
  output logic               ir_ready,
  output logic [4:0]         out_op,
  output logic [WIDTH-1:0]   out_in1,
  output logic [WIDTH-1:0]   out_in2,
  output logic [REGBITS-1:0] out_dest,
  output logic               out_wr,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               wb_en,
  input  logic [REGBITS-1:0] wb_reg,
  input  logic [WIDTH-1:0]   wb_data
);

  logic [WIDTH-1:0]   r_rf [NREGS];

  logic [3:0]         w_opc;
  logic [REGBITS-1:0] w_dest;
  logic [REGBITS-1:0] w_src;
  logic               w_wr;
  logic               w_pend_dest;
  logic               w_pend_src;
  logic               w_hazard;
  logic               w_slot_free;
  logic               w_fire;
  logic [WIDTH-1:0]   w_in1;
  logic [WIDTH-1:0]   w_in2;

  logic [4:0]         r_op;
  logic [WIDTH-1:0]   r_in1;
  logic [WIDTH-1:0]   r_in2;
  logic [REGBITS-1:0] r_dest;
  logic               r_wr;
  logic               r_valid;

  // Decode, hazard and handshake; pass-through ops never stall on pending
  always_comb begin
    w_opc       = ir[OPC_HI:OPC_LO];
    w_dest      = ir[DEST_HI:DEST_LO];
    w_src       = ir[SRC_HI:SRC_LO];
    w_wr        = writes_dest(w_opc);
    w_hazard    = w_wr && (w_pend_dest || w_pend_src);
    w_slot_free = !r_valid || out_ready;
    ir_ready    = w_slot_free && !w_hazard;
    w_fire      = ir_valid && ir_ready;
  end

  // Operand read with same-cycle writeback bypass
  always_comb begin
    w_in1 = (wb_en && (wb_reg == w_dest)) ? wb_data : r_rf[w_dest];
    w_in2 = (wb_en && (wb_reg == w_src))  ? wb_data : r_rf[w_src];
  end

  op_scoreboard #(
    .NREGS   (NREGS),
    .REGBITS (REGBITS)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .i_set_en  (w_fire && w_wr),
    .i_set_reg (w_dest),
    .i_clr_en  (wb_en),
    .i_clr_reg (wb_reg),
    .i_qa_reg  (w_dest),
    .i_qb_reg  (w_src),
    .o_qa_pend (w_pend_dest),
    .o_qb_pend (w_pend_src)
  );

  // Register file: writebacks land regardless of stalls
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else if (wb_en) begin
      r_rf[wb_reg] <= wb_data;
    end
  end

  // Output register: load on fire, drop valid when consumed, otherwise hold
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_op    <= '0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_dest  <= '0;
      r_wr    <= 1'b0;
    end else if (w_fire) begin
      r_valid <= 1'b1;
      r_op    <= {1'b0, w_opc};
      r_in1   <= w_in1;
      r_in2   <= w_in2;
      r_dest  <= w_dest;
      r_wr    <= w_wr;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_op    = r_op;
  assign out_in1   = r_in1;
  assign out_in2   = r_in2;
  assign out_dest  = r_dest;
  assign out_wr    = r_wr;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: issue, hazard stall/release via writeback,
// output back-pressure, set/clear collision, pass-through ops and reset.
module tb_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic [4:0]  out_op;
  logic [15:0] out_in1;
  logic [15:0] out_in2;
  logic [5:0]  out_dest;
  logic        out_wr;
  logic        out_valid;
  logic        out_ready;
  logic        wb_en;
  logic [5:0]  wb_reg;
  logic [15:0] wb_data;

  int errors = 0;
  int checks = 0;

  operand_stage dut (
    .clk       (clk),
    .reset     (reset),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .ir_ready  (ir_ready),
    .out_op    (out_op),
    .out_in1   (out_in1),
    .out_in2   (out_in2),
    .out_dest  (out_dest),
    .out_wr    (out_wr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .wb_en     (wb_en),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // advance one edge, then settle inputs/outputs 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; ir = '0; ir_valid = 1'b0; out_ready = 1'b1;
    wb_en = 1'b0; wb_reg = '0; wb_data = '0;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("rst_valid", {15'b0, out_valid}, 16'h0);
    chk("rst_op",    {11'b0, out_op},    16'h0);
    chk("rst_in1",   out_in1,            16'h0);
    chk("rst_in2",   out_in2,            16'h0);
    chk("rst_dest",  {10'b0, out_dest},  16'h0);
    chk("rst_wr",    {15'b0, out_wr},    16'h0);
    chk("rst_ready", {15'b0, ir_ready},  16'h1);

    // add r1,r2
    ir = 16'h0042; ir_valid = 1'b1;
    #1 chk("iss1_ready", {15'b0, ir_ready}, 16'h1);
    tick();
    ir_valid = 1'b0;
    #1;
    chk("iss1_valid", {15'b0, out_valid}, 16'h1);
    chk("iss1_op",    {11'b0, out_op},    16'h0);
    chk("iss1_dest",  {10'b0, out_dest},  16'h1);
    chk("iss1_in1",   out_in1,            16'h0);
    chk("iss1_in2",   out_in2,            16'h0);
    chk("iss1_wr",    {15'b0, out_wr},    16'h1);

    // add r2,r1 stalls on pending r1
    ir = 16'h0081; ir_valid = 1'b1;
    #1 chk("raw_stall", {15'b0, ir_ready}, 16'h0);
    tick();
    chk("drain_valid", {15'b0, out_valid}, 16'h0);
    chk("raw_stall2", {15'b0, ir_ready}, 16'h0);
    wb_en = 1'b1; wb_reg = 6'd1; wb_data = 16'h1234;
    #1 chk("raw_release", {15'b0, ir_ready}, 16'h1);
    tick();
    wb_en = 1'b0; ir_valid = 1'b0;
    #1;
    chk("byp_in2",  out_in2,           16'h1234);
    chk("byp_in1",  out_in1,           16'h0);
    chk("byp_dest", {10'b0, out_dest}, 16'h2);

    // back-pressure: hold 3 cycles, then back-to-back issue of add r3,r3
    out_ready = 1'b0; ir = 16'h00C3; ir_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready", {15'b0, ir_ready},  16'h0);
      chk("hold_dest",  {10'b0, out_dest},  16'h2);
      chk("hold_in2",   out_in2,            16'h1234);
      chk("hold_valid", {15'b0, out_valid}, 16'h1);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("b2b_ready", {15'b0, ir_ready}, 16'h1);
    tick();
    ir_valid = 1'b0;
    #1;
    chk("b2b_valid", {15'b0, out_valid}, 16'h1);
    chk("b2b_dest",  {10'b0, out_dest},  16'h3);

    // retire r2 and r3
    wb_en = 1'b1; wb_reg = 6'd2; wb_data = 16'h0022;
    tick();
    wb_reg = 6'd3; wb_data = 16'h0033;
    tick();
    wb_en = 1'b0;

    // add r5,r1 issued while r5 writes back: set wins, in1 bypassed
    ir = 16'h0141; ir_valid = 1'b1;
    wb_en = 1'b1; wb_reg = 6'd5; wb_data = 16'h0055;
    #1 chk("col_ready", {15'b0, ir_ready}, 16'h1);
    tick();
    wb_en = 1'b0;
    ir = 16'h0185;
    #1;
    chk("col_in1",   out_in1, 16'h0055);
    chk("col_in2",   out_in2, 16'h1234);
    chk("col_stall", {15'b0, ir_ready}, 16'h0);
    tick();
    chk("col_stall2", {15'b0, ir_ready}, 16'h0);
    wb_en = 1'b1; wb_reg = 6'd5; wb_data = 16'h5555;
    #1 chk("col_release", {15'b0, ir_ready}, 16'h1);
    tick();
    wb_en = 1'b0;
    #1;
    chk("col_rd_in2", out_in2,           16'h5555);
    chk("col_rd_dst", {10'b0, out_dest}, 16'h6);

    // pass-through op against pending r0
    ir = 16'h0000;
    tick();
    ir = 16'hC000;
    #1 chk("pt_ready", {15'b0, ir_ready}, 16'h1);
    tick();
    out_ready = 1'b0; ir_valid = 1'b0;
    #1;
    chk("pt_op",    {11'b0, out_op},    16'h000C);
    chk("pt_wr",    {15'b0, out_wr},    16'h0);
    chk("pt_valid", {15'b0, out_valid}, 16'h1);
    ir = 16'h0000;
    out_ready = 1'b1;
    #1 chk("pt_pend_kept", {15'b0, ir_ready}, 16'h0);
    out_ready = 1'b0;

    // reset with a held output, pending bits and a concurrent writeback
    reset = 1'b0; wb_en = 1'b1; wb_reg = 6'd1; wb_data = 16'hFFFF;
    tick();
    reset = 1'b1; wb_en = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst2_valid", {15'b0, out_valid}, 16'h0);
    chk("rst2_op",    {11'b0, out_op},    16'h0);
    chk("rst2_pend",  {15'b0, ir_ready},  16'h1);
    ir = 16'h0041; ir_valid = 1'b1;
    tick();
    ir_valid = 1'b0;
    #1;
    chk("rst2_rf1_in1", out_in1, 16'h0);
    chk("rst2_rf1_in2", out_in2, 16'h0);
    chk("rst2_valid2",  {15'b0, out_valid}, 16'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed=stuck expected=finish");
    $fatal(1, "timeout");
  end

endmodule
